// File: rtl/alu4_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu4_op_sequencer
//
// Sequencing and output stage wrapped around the 4-bit ALU mux bank. One
// operation is in flight at a time: a request (two operands + opcode) is
// accepted over a valid/ready handshake, the operands and select pair are held
// stable for the mux bank, the selected lane result is sampled after one
// settle cycle, and a registered result with carry/zero flags is presented on
// a valid/ready output port.
//
// State table:
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; in_ready = 1
//   EXEC  | mux bank settling on op_a/op_b/sel; result sampled at exit edge
//   DONE  | result presented (out_valid = 1); in_ready follows out_ready so a
//         | new request can be taken on the same edge the result is consumed
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_a, in_b, in_op    operands and opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
//   op_a, op_b, sel      held operands and {S1,S0} driven to the mux bank
//   alu_y, alu_c         mux bank result and adder-lane carry
//   out_valid/out_ready  result handshake
//   out_y, out_c, out_z  registered result, carry flag, zero flag
//   done_count           completed-transaction counter (wraps at 256)
//   busy                 high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu4_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             out_z,
  output logic [7:0]       done_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_c_q, out_c_d;
  logic             out_z_q, out_z_d;
  logic [7:0]       done_count_q, done_count_d;

  logic accept;
  logic out_fire;

  // Handshake decodes depend only on state and out_ready, never on in_valid,
  // so upstream logic can use in_ready without forming a combinational loop.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    sel_d        = sel_q;
    out_y_d      = out_y_q;
    out_c_d      = out_c_q;
    out_z_d      = out_z_q;
    done_count_d = done_count_q;

    // Operands and select move only on an accepted request; this covers both
    // the IDLE acceptance and the back-to-back acceptance from DONE.
    if (accept) begin
      op_a_d = in_a;
      op_b_d = in_b;
      sel_d  = in_op;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        out_y_d = alu_y;
        // Logic lanes have no meaningful carry; only the adder lane reports it.
        out_c_d = (sel_q[1] == 1'b0) ? alu_c : 1'b0;
        out_z_d = (alu_y == '0);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = in_valid ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_fire) done_count_d = done_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      sel_q        <= 2'b00;
      out_y_q      <= '0;
      out_c_q      <= 1'b0;
      out_z_q      <= 1'b0;
      done_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      sel_q        <= sel_d;
      out_y_q      <= out_y_d;
      out_c_q      <= out_c_d;
      out_z_q      <= out_z_d;
      done_count_q <= done_count_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign sel        = sel_q;
  assign out_y      = out_y_q;
  assign out_c      = out_c_q;
  assign out_z      = out_z_q;
  assign done_count = done_count_q;

endmodule
